// File: rtl/p2s_sequencer.sv
// Sequencer for the phase2speed datapath: buffers phase words, strobes samples on a
// programmable cadence, captures speed results and owns datapath reset/meanlen.
module p2s_sequencer #(
  parameter int         CAP_DELAY       = 1,
  parameter int         DEFAULT_DIV     = 5,
  parameter logic [3:0] DEFAULT_MEANLEN = 4'd4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [7:0]         cfg_div,
  input  logic [3:0]         cfg_meanlen,
  output logic               cfg_busy,
  input  logic               in_valid,
  input  logic signed [18:0] in_phase,
  output logic               in_ready,
  output logic               p2s_reset,
  output logic               p2s_sample,
  output logic [3:0]         p2s_meanlen,
  output logic signed [18:0] p2s_phase,
  input  logic signed [15:0] p2s_speed,
  input  logic               p2s_ready,
  output logic               out_valid,
  output logic signed [15:0] out_speed,
  input  logic               out_ready,
  output logic               underrun,
  output logic               overrun
);

  localparam logic [7:0] MIN_DIV = 8'(CAP_DELAY + 1);
  localparam logic [7:0] RST_DIV = 8'(DEFAULT_DIV);

  typedef enum logic {S_FLUSH, S_RUN} state_t;

  state_t                 r_state;
  logic                   r_fcnt;
  logic [7:0]             r_div;
  logic [7:0]             r_cnt;
  logic [3:0]             r_meanlen;
  logic                   r_full;
  logic                   r_in_ready;
  logic signed [18:0]     r_phase;
  logic [CAP_DELAY-1:0]   r_cap_vld;
  logic                   r_out_valid;
  logic signed [15:0]     r_out_speed;
  logic                   r_underrun;
  logic                   r_overrun;

  logic                   w_restart;
  logic [7:0]             w_eff_div;
  logic [7:0]             w_eff_m1;
  logic                   w_tick;
  logic                   w_sample;
  logic                   w_load;
  logic                   w_capture;
  logic [CAP_DELAY-1:0]   w_cap_nxt;

  // A flush request in the tick cycle suppresses the strobe, so the sample gate
  // looks at the restart inputs directly.
  assign w_restart = reset || cfg_we;
  assign w_eff_div = (r_div < MIN_DIV) ? MIN_DIV : r_div;
  assign w_eff_m1  = w_eff_div - 8'd1;
  assign w_tick    = (r_state == S_RUN) && (r_cnt == 8'd0);
  assign w_sample  = w_tick && r_full && !w_restart;
  assign w_load    = in_valid && r_in_ready;
  assign w_capture = r_cap_vld[CAP_DELAY-1] && p2s_ready;

  always_comb begin
    w_cap_nxt    = '0;
    w_cap_nxt[0] = w_sample;
    for (int i = 1; i < CAP_DELAY; i++) begin
      w_cap_nxt[i] = r_cap_vld[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (w_restart) begin
      r_state     <= S_FLUSH;
      r_fcnt      <= 1'b0;
      r_full      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_phase     <= '0;
      r_cap_vld   <= '0;
      r_out_valid <= 1'b0;
      r_underrun  <= 1'b0;
      r_overrun   <= 1'b0;
      if (reset) begin
        r_div       <= RST_DIV;
        r_meanlen   <= DEFAULT_MEANLEN;
        r_out_speed <= '0;
      end else begin
        r_div       <= cfg_div;
        r_meanlen   <= cfg_meanlen;
      end
    end else begin
      r_cap_vld <= w_cap_nxt;
      if (r_state == S_FLUSH) begin
        r_cnt  <= w_eff_m1;
        r_fcnt <= 1'b1;
        if (r_fcnt) begin
          r_state    <= S_RUN;
          r_in_ready <= 1'b1;
        end
      end else begin
        // Ticks keep their cadence whether or not a word is waiting.
        r_cnt <= w_tick ? w_eff_m1 : r_cnt - 8'd1;
        if (w_sample) begin
          r_full     <= 1'b0;
          r_in_ready <= 1'b1;
        end else begin
          if (w_tick) r_underrun <= 1'b1;
          if (w_load) begin
            r_full     <= 1'b1;
            r_in_ready <= 1'b0;
            r_phase    <= in_phase;
          end
        end
      end
      // Capture stage: a matured strobe with a valid result overwrites the output.
      if (w_capture) begin
        r_out_speed <= p2s_speed;
        r_out_valid <= 1'b1;
        if (r_out_valid && !out_ready) r_overrun <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign cfg_busy    = (r_state == S_FLUSH);
  assign p2s_reset   = (r_state == S_FLUSH);
  assign in_ready    = r_in_ready;
  assign p2s_sample  = w_sample;
  assign p2s_meanlen = r_meanlen;
  assign p2s_phase   = r_phase;
  assign out_valid   = r_out_valid;
  assign out_speed   = r_out_speed;
  assign underrun    = r_underrun;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_p2s_sequencer.sv
// Scoreboard bench for p2s_sequencer: a cycle-level reference model predicts strobes,
// captures and status flags; a negedge monitor pops and compares.
module tb_p2s_sequencer;
  localparam int CAP = 1;

  logic               clock = 1'b0;
  logic               reset, cfg_we, cfg_busy, in_valid, in_ready;
  logic [7:0]         cfg_div;
  logic [3:0]         cfg_meanlen, p2s_meanlen;
  logic signed [18:0] in_phase, p2s_phase;
  logic               p2s_reset, p2s_sample, p2s_ready;
  logic signed [15:0] p2s_speed, out_speed;
  logic               out_valid, out_ready, underrun, overrun;

  always #5 clock = ~clock;

  p2s_sequencer dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_div(cfg_div),
    .cfg_meanlen(cfg_meanlen), .cfg_busy(cfg_busy), .in_valid(in_valid),
    .in_phase(in_phase), .in_ready(in_ready), .p2s_reset(p2s_reset),
    .p2s_sample(p2s_sample), .p2s_meanlen(p2s_meanlen), .p2s_phase(p2s_phase),
    .p2s_speed(p2s_speed), .p2s_ready(p2s_ready), .out_valid(out_valid),
    .out_speed(out_speed), .out_ready(out_ready), .underrun(underrun),
    .overrun(overrun)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {int cyc; logic signed [18:0] ph;} stb_t;
  typedef struct {int cyc; logic signed [15:0] sp;} out_t;
  stb_t sq[$];
  out_t oq[$];
  int   mat_q[$];

  // reference model state
  bit                 m_on = 0, m_run = 0, m_full = 0, m_ov = 0, m_under = 0, m_over = 0;
  int                 m_fl = 0, m_idx = 0, m_div = 5;
  logic [3:0]         m_ml = 4'd4;
  logic signed [18:0] m_buf = '0;
  logic signed [15:0] m_os = '0;
  // expected visible values for the current cycle
  bit                 e_on = 0, e_busy, e_inrdy, e_under, e_over, e_ov;
  logic [3:0]         e_ml;
  logic signed [15:0] e_os;

  // next-cycle stimulus
  logic               n_rst, n_we, n_iv, n_pr, n_ordy;
  logic [7:0]         n_wdiv;
  logic [3:0]         n_wml;
  logic signed [18:0] n_ip;
  logic signed [15:0] n_ps;

  task automatic model_eval();
    bit restart, tick, cap;
    e_on = m_on; e_busy = !m_run; e_inrdy = m_run && !m_full; e_ml = m_ml;
    e_under = m_under; e_over = m_over; e_ov = m_ov; e_os = m_os;
    restart = reset || cfg_we;
    cap = 0;
    if (m_run && !restart) begin
      m_idx++;
      tick = (m_idx % m_div) == 0;
      if (tick && m_full) begin
        sq.push_back('{cyc, m_buf});
        mat_q.push_back(cyc + CAP);
        m_full = 0;
      end else begin
        if (tick) m_under = 1;
        if (in_valid && !m_full) begin m_full = 1; m_buf = in_phase; end
      end
    end
    if (!restart && mat_q.size() > 0 && mat_q[0] == cyc) begin
      void'(mat_q.pop_front());
      cap = p2s_ready;
    end
    if (!restart) begin
      if (cap) begin
        if (m_ov && !out_ready) m_over = 1;
        m_ov = 1; m_os = p2s_speed;
        oq.push_back('{cyc + 1, p2s_speed});
      end else if (m_ov && out_ready) m_ov = 0;
    end
    if (restart) begin
      m_run = 0; m_fl = 2; m_full = 0; m_buf = '0; mat_q.delete();
      m_ov = 0; m_under = 0; m_over = 0;
      if (reset) begin m_div = 5; m_ml = 4'd4; m_os = '0; m_on = 1; end
      else begin m_div = (int'(cfg_div) < CAP + 1) ? CAP + 1 : int'(cfg_div); m_ml = cfg_meanlen; end
    end else if (!m_run) begin
      m_fl--;
      if (m_fl == 0) begin m_run = 1; m_idx = 0; end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    reset = n_rst; cfg_we = n_we; cfg_div = n_wdiv; cfg_meanlen = n_wml;
    in_valid = n_iv; in_phase = n_ip; p2s_ready = n_pr; p2s_speed = n_ps; out_ready = n_ordy;
    model_eval();
  endtask

  stb_t mon_s;
  out_t mon_o;
  always @(negedge clock) begin
    if (e_on) begin
      chk("in_ready", 32'(in_ready), 32'(e_inrdy));
      chk("cfg_busy", 32'(cfg_busy), 32'(e_busy));
      chk("p2s_reset", 32'(p2s_reset), 32'(e_busy));
      chk("p2s_meanlen", 32'(p2s_meanlen), 32'(e_ml));
      chk("underrun", 32'(underrun), 32'(e_under));
      chk("overrun", 32'(overrun), 32'(e_over));
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      if (e_ov) chk("out_speed_held", 32'(out_speed), 32'(e_os));
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        mon_s = sq.pop_front();
        chk("strobe", 32'(p2s_sample), 32'd1);
        chk("strobe_phase", 32'(p2s_phase), 32'(mon_s.ph));
      end else begin
        chk("no_strobe", 32'(p2s_sample), 32'd0);
      end
      if (oq.size() > 0 && oq[0].cyc == cyc) begin
        mon_o = oq.pop_front();
        chk("capture_valid", 32'(out_valid), 32'd1);
        chk("capture_speed", 32'(out_speed), 32'(mon_o.sp));
      end
    end
  end

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_div = '0; cfg_meanlen = '0; in_valid = 1'b0;
    in_phase = '0; p2s_ready = 1'b0; p2s_speed = '0; out_ready = 1'b1;
    n_rst = 1'b1; n_we = 1'b0; n_wdiv = '0; n_wml = '0; n_iv = 1'b0; n_ip = '0;
    n_pr = 1'b0; n_ps = '0; n_ordy = 1'b1;

    step(); step();
    n_rst = 1'b0;
    step();
    @(negedge clock);
    chk("rst_out_speed", 32'(out_speed), 32'd0);
    chk("rst_p2s_phase", 32'(p2s_phase), 32'd0);
    chk("rst_sample", 32'(p2s_sample), 32'd0);
    chk("rst_busy", 32'(cfg_busy), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    // default cadence, word offered every cycle, datapath returns 1.0
    n_iv = 1'b1; n_pr = 1'b1; n_ps = 16'sh0400; n_ordy = 1'b1;
    repeat (40) begin n_ip = 19'($urandom); step(); end

    // starve the input
    n_iv = 1'b0;
    repeat (20) step();
    @(negedge clock);
    chk("starve_underrun", 32'(underrun), 32'd1);

    // consumer stalls across several captures
    n_iv = 1'b1; n_ordy = 1'b0; n_ps = 16'sh0400;
    repeat (12) begin n_ip = 19'($urandom); step(); end
    n_ps = 16'sh0800;
    repeat (12) begin n_ip = 19'($urandom); step(); end
    @(negedge clock);
    chk("stall_overrun", 32'(overrun), 32'd1);
    chk("stall_speed", 32'(out_speed), 32'h0800);

    // reconfigure mid-stream: div=2, meanlen=8
    n_ordy = 1'b1;
    repeat (3) begin n_ip = 19'($urandom); step(); end
    n_we = 1'b1; n_wdiv = 8'd2; n_wml = 4'd8;
    step();
    n_we = 1'b0;
    repeat (20) begin n_ip = 19'($urandom); step(); end
    @(negedge clock);
    chk("cfg_meanlen", 32'(p2s_meanlen), 32'd8);

    // div=0 clamps to the minimum period
    n_we = 1'b1; n_wdiv = 8'd0; n_wml = 4'd3;
    step();
    n_we = 1'b0;
    repeat (20) begin n_ip = 19'($urandom); step(); end

    // randomized traffic with occasional reconfig and reset
    repeat (600) begin
      n_rst  = ($urandom_range(0, 249) == 0);
      n_we   = ($urandom_range(0, 39) == 0);
      n_wdiv = 8'($urandom_range(0, 7));
      n_wml  = 4'($urandom);
      n_iv   = ($urandom_range(0, 3) != 0);
      n_ip   = 19'($urandom);
      n_pr   = ($urandom_range(0, 3) != 0);
      n_ps   = 16'($urandom);
      n_ordy = ($urandom_range(0, 3) != 0);
      step();
    end

    n_rst = 1'b0; n_we = 1'b0; n_iv = 1'b0; n_ordy = 1'b1;
    repeat (20) step();
    @(negedge clock);
    chk("strobe_queue_drained", 32'(sq.size()), 32'd0);
    chk("capture_queue_drained", 32'(oq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/p2s_sequencer.md
# p2s_sequencer

Controller that sequences the `phase2speed` datapath. It buffers incoming phase-difference words and issues `sample` strobes on a programmable cadence. It captures `speed` results into a valid/ready output register and owns the datapath's reset and `meanlen` configuration. It sits between the Hilbert phase-difference stage and the downstream speed consumer, one instance per axis (X, Y).

## Interface
- `CAP_DELAY`, 1: cycles from a `p2s_sample` pulse to the cycle `p2s_ready`/`p2s_speed` are sampled.
- `DEFAULT_DIV`, 5: sample period in clocks after reset.
- `DEFAULT_MEANLEN`, 4'd4: `meanlen` after reset.
- `clock` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `cfg_we` in 1: one-cycle config write strobe.
- `cfg_div` in 8: new sample period, in clocks.
- `cfg_meanlen` in 4: new averaging length.
- `cfg_busy` out 1: high while the datapath is being flushed.
- `in_valid` in 1: phase word offered.
- `in_phase` in 19, signed: phase difference.
- `in_ready` out 1: input holding register empty.
- `p2s_reset` out 1: datapath reset.
- `p2s_sample` out 1: one-cycle sample strobe.
- `p2s_meanlen` out 4: datapath averaging length.
- `p2s_phase` out 19, signed: phase presented to the datapath.
- `p2s_speed` in 16, signed: datapath result, Q5.10.
- `p2s_ready` in 1: datapath result valid.
- `out_valid` out 1: captured speed available.
- `out_speed` out 16, signed: captured speed.
- `out_ready` in 1: consumer accepts.
- `underrun` out 1: sticky. A tick occurred with no phase buffered.
- `overrun` out 1: sticky. A capture overwrote an unaccepted result.

## Operation
- States: FLUSH and RUN.
- FLUSH:
  - Entered on `reset` (synchronously) or on `cfg_we` in any state.
  - Drives `p2s_reset`=1 for exactly 2 cycles, then goes to RUN.
  - `cfg_busy`=1 throughout.
  - Clears the holding register, `out_valid`, the capture pipeline, `underrun` and `overrun`.
  - Loads the divider counter with the effective div minus 1.
  - `cfg_we` during FLUSH restarts FLUSH with the new values.
- Config latching:
  - `cfg_we` latches `cfg_div` and `cfg_meanlen` into registers in the cycle it is high.
  - `p2s_meanlen` changes only from these registers.
  - Effective div = max(`cfg_div`, `CAP_DELAY`+1).
  - On `reset`: div=`DEFAULT_DIV`, meanlen=`DEFAULT_MEANLEN`.
- Input side:
  - 1-entry holding register drives `p2s_phase` continuously.
  - `in_ready` = !full, registered.
  - Load when `in_valid`&&`in_ready`.
  - `in_valid` while `in_ready`=0 is ignored (the word is not consumed).
- Divider (RUN only):
  - Counts down. At 0, reloads to effective div minus 1: a tick.
  - On a tick with the register full: `p2s_sample`=1 for that cycle, and the register empties at the same edge.
  - On a tick with the register empty: no strobe, and `underrun` is set.
  - Ticks continue regardless of buffer state, so cadence is fixed.
- Capture:
  - A `CAP_DELAY`-deep shift register tracks strobes.
  - When a tracked strobe matures and `p2s_ready`=1: `out_speed` loads `p2s_speed` and `out_valid` sets.
  - If `p2s_ready`=0 (averaging window not yet filled), nothing is captured.
- Output:
  - `out_valid` clears on `out_valid`&&`out_ready` unless a capture happens in the same cycle, in which case it stays 1 with the new data.
  - Capture while `out_valid`&&!`out_ready`: overwrite the result and set `overrun`.
- Arithmetic: no arithmetic on data. Words pass bit-exact, with no sign extension or rounding.

## Timing
- Reset values (the cycle after `reset`):
  - `cfg_busy`=1, `p2s_reset`=1, `in_ready`=0.
  - `p2s_sample`=0, `out_valid`=0, `out_speed`=0, `p2s_phase`=0.
  - `underrun`=0, `overrun`=0, `p2s_meanlen`=`DEFAULT_MEANLEN`.
- FLUSH occupies 2 cycles. `in_ready` rises in the first RUN cycle.
- First tick comes effective-div cycles after entering RUN. Ticks then repeat every effective-div cycles.
- A word accepted at edge N is eligible for the first tick at or after cycle N+1.
- `in_ready` re-asserts 1 cycle after the strobe cycle.
- Strobe at cycle T: `p2s_ready`/`p2s_speed` are sampled at T+`CAP_DELAY`, and `out_valid` is visible at T+`CAP_DELAY`+1.
- Reset mid-operation: behaves exactly as power-on reset. All in-flight strobes and captures are discarded.
- `cfg_we` coincident with a tick: FLUSH wins and no strobe is issued.

## Test plan
- Reset, then run with default config and feed a word every cycle when `in_ready`:
  - `p2s_reset` is high for 2 cycles.
  - `p2s_sample` pulses every 5 cycles, with the first pulse 5 cycles into RUN.
  - `p2s_phase` matches the offered words in order.
- Datapath model asserts `p2s_ready` with speed 16'h0400 (1.0 in Q5.10), `out_ready`=1:
  - Captured value and its arrival 2 cycles after each strobe match this model.
  - `overrun`=0.
- Input starved after 3 words: `underrun` sets on the 4th tick, no strobe is issued, and cadence is unchanged.
- `out_ready`=0 across two captures (0x0400, 0x0800): `out_speed`=0x0800 and `overrun`=1.
- `cfg_we` with div=2 and meanlen=8 while mid-stream:
  - `cfg_busy` is high for 2 cycles.
  - `out_valid` is cleared and the buffered word is dropped.
  - `p2s_meanlen`=8 and strobes come every 2 cycles.
- `cfg_div`=0 with `CAP_DELAY`=1: effective period is 2, giving strobes at T and T+2.
